inst_fetch_unit: RTL and testbench

- Multicycle instruction-fetch stage that owns the program counter and drives the instruction-memory read port.
- Captures the returned word and presents it to the decoder/execute stage over a valid/ready handshake.
- Accepts a redirect (branch/jump target) from the write-back stage.
- Sits directly upstream of the decoder and feeds it the current instruction and its PC.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/inst_fetch_unit_if.sv | 26 ++
 rtl/inst_fetch_unit.sv | 94 +++++++++
 tb/tb_inst_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and architectural constants.
package riscv_pkg;

   localparam int unsigned     XLEN        = 32;
   localparam int unsigned     INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;
   localparam logic [XLEN-1:0] IMEM_BASE   = 32'h0000_1000;

   typedef enum logic [1:0] {ISSUE, WAIT, VALID, FAULT} fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, decoder handshake and redirect input.
interface inst_fetch_unit_if;
   import riscv_pkg::*;

   logic [XLEN-1:0] imem_address;
   logic [XLEN-1:0] imem_data_out;
   logic            instr_valid;
   logic            instr_ready;
   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] instr_pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic [XLEN-1:0] fetch_count;
   logic            fetch_fault;

   modport master (
      output imem_address, instr_valid, instr, instr_pc, fetch_count, fetch_fault,
      input  imem_data_out, instr_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_address, instr_valid, instr, instr_pc, fetch_count, fetch_fault,
      output imem_data_out, instr_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/inst_fetch_unit.sv
// Multicycle instruction fetch: owns the PC, reads imem, hands words to decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects lock the unit in FAULT until reset.
module inst_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC     = IMEM_BASE,
   parameter int unsigned     IMEM_LATENCY = 1,
   parameter logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013
) (
   input logic                clk,
   input logic                reset,
   inst_fetch_unit_if.master  bus
);

   localparam int unsigned      CNT_W    = $clog2(IMEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_LATENCY - 1);
   localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(INSTR_BYTES);

   fetch_state_t     state_q;
   logic [XLEN-1:0]  pc_q;
   logic [XLEN-1:0]  instr_q;
   logic [XLEN-1:0]  instr_pc_q;
   logic [XLEN-1:0]  count_q;
   logic [CNT_W-1:0] wait_cnt_q;
   logic             valid_q;
   logic             handshake;
   logic             fault_entry;
   logic [XLEN-1:0]  target;

   assign handshake = valid_q && bus.instr_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign target          = bus.redirect_pc;
   assign fault_entry     = |bus.redirect_pc[1:0];
   assign bus.fetch_fault = (state_q == FAULT);
`else
   assign target          = bus.redirect_pc & ~(PC_STEP - XLEN'(1));
   assign fault_entry     = 1'b0;
   assign bus.fetch_fault = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ISSUE;
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         instr_pc_q <= '0;
         count_q    <= '0;
         wait_cnt_q <= '0;
      end else begin
         // A handshake counts even when a redirect overrides the next PC.
         if (handshake) begin
            count_q <= count_q + XLEN'(1);
         end
         if (bus.redirect_valid && state_q != FAULT) begin
            pc_q    <= target;
            valid_q <= 1'b0;
            state_q <= fault_entry ? FAULT : ISSUE;
         end else begin
            unique case (state_q)
               ISSUE: begin
                  state_q    <= WAIT;
                  wait_cnt_q <= '0;
               end
               WAIT: begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                  if (wait_cnt_q == CNT_LAST) begin
                     instr_q    <= bus.imem_data_out;
                     instr_pc_q <= pc_q;
                     valid_q    <= 1'b1;
                     state_q    <= VALID;
                  end
               end
               VALID: begin
                  if (handshake) begin
                     pc_q    <= pc_q + PC_STEP;
                     valid_q <= 1'b0;
                     state_q <= ISSUE;
                  end
               end
               FAULT: state_q <= FAULT;
            endcase
         end
      end
   end

   assign bus.imem_address = pc_q;
   assign bus.instr_valid  = valid_q;
   assign bus.instr        = instr_q;
   assign bus.instr_pc     = instr_pc_q;
   assign bus.fetch_count  = count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench: two fetch units (latency 1 and 3) against a transaction-level model.
module tb_inst_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_1000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst [2];
   logic        ready;
   logic        redir_v;
   logic [31:0] redir_pc;

   logic [31:0] o_addr [2];
   logic [31:0] o_instr [2];
   logic [31:0] o_ipc [2];
   logic [31:0] o_cnt [2];
   logic        o_valid [2];
   logic        o_fault [2];

   // Reference model: cycles left until a fetched word becomes visible.
   logic [31:0] m_pc [2];
   logic [31:0] m_instr [2];
   logic [31:0] m_ipc [2];
   logic [31:0] m_cnt [2];
   logic        m_valid [2];
   logic        m_fault [2];
   int          m_left [2];

   int n_assert;
   int n_fail;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_1000) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   inst_fetch_unit_if bus0 ();
   inst_fetch_unit_if bus1 ();

   assign bus0.imem_data_out  = mem_word(bus0.imem_address);
   assign bus0.instr_ready    = ready;
   assign bus0.redirect_valid = redir_v;
   assign bus0.redirect_pc    = redir_pc;
   assign bus1.imem_data_out  = mem_word(bus1.imem_address);
   assign bus1.instr_ready    = ready;
   assign bus1.redirect_valid = redir_v;
   assign bus1.redirect_pc    = redir_pc;

   assign o_addr[0]  = bus0.imem_address;
   assign o_instr[0] = bus0.instr;
   assign o_ipc[0]   = bus0.instr_pc;
   assign o_cnt[0]   = bus0.fetch_count;
   assign o_valid[0] = bus0.instr_valid;
   assign o_fault[0] = bus0.fetch_fault;
   assign o_addr[1]  = bus1.imem_address;
   assign o_instr[1] = bus1.instr;
   assign o_ipc[1]   = bus1.instr_pc;
   assign o_cnt[1]   = bus1.fetch_count;
   assign o_valid[1] = bus1.instr_valid;
   assign o_fault[1] = bus1.fetch_fault;

   inst_fetch_unit #(.IMEM_LATENCY(1)) dut0 (
      .clk   (clk),
      .reset (rst[0]),
      .bus   (bus0)
   );

   inst_fetch_unit #(.IMEM_LATENCY(3)) dut1 (
      .clk   (clk),
      .reset (rst[1]),
      .bus   (bus1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int i);
      m_pc[i]    = RESET_PC;
      m_instr[i] = NOP;
      m_ipc[i]   = '0;
      m_cnt[i]   = '0;
      m_valid[i] = 1'b0;
      m_fault[i] = 1'b0;
      m_left[i]  = lat_of(i) + 1;
   endtask

   task automatic step(input int i);
      logic hs;
      if (rst[i]) begin
         model_reset(i);
      end else if (!m_fault[i]) begin
         hs = m_valid[i] && ready;
         if (hs) m_cnt[i] = m_cnt[i] + 1;
         if (redir_v) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc[i]    = redir_pc;
            m_fault[i] = (redir_pc[1:0] != 2'b00);
`else
            m_pc[i]    = redir_pc & 32'hFFFF_FFFC;
`endif
            m_valid[i] = 1'b0;
            m_left[i]  = lat_of(i) + 1;
         end else if (m_valid[i]) begin
            if (hs) begin
               m_pc[i]    = m_pc[i] + 32'd4;
               m_valid[i] = 1'b0;
               m_left[i]  = lat_of(i) + 1;
            end
         end else begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
               m_valid[i] = 1'b1;
               m_instr[i] = mem_word(m_pc[i]);
               m_ipc[i]   = m_pc[i];
            end
         end
      end
   endtask

   task automatic check_dut(input int i);
      chk($sformatf("d%0d imem_address", i), o_addr[i], m_pc[i]);
      chk($sformatf("d%0d instr_valid", i), 32'(o_valid[i]), 32'(m_valid[i]));
      chk($sformatf("d%0d instr", i), o_instr[i], m_instr[i]);
      chk($sformatf("d%0d instr_pc", i), o_ipc[i], m_ipc[i]);
      chk($sformatf("d%0d fetch_count", i), o_cnt[i], m_cnt[i]);
      chk($sformatf("d%0d fetch_fault", i), 32'(o_fault[i]), 32'(m_fault[i]));
   endtask

   task automatic cycle();
      @(posedge clk);
      for (int i = 0; i < 2; i++) step(i);
      #1;
      for (int i = 0; i < 2; i++) check_dut(i);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      n_assert = 0;
      n_fail   = 0;
      rst[0]   = 1'b1;
      rst[1]   = 1'b1;
      ready    = 1'b0;
      redir_v  = 1'b0;
      redir_pc = '0;
      for (int i = 0; i < 2; i++) model_reset(i);
      cycle();
      cycle();
      chk("reset imem_address", o_addr[0], 32'h0000_1000);
      chk("reset instr_valid", 32'(o_valid[0]), 32'd0);
      chk("reset instr", o_instr[0], 32'h0000_0013);
      chk("reset instr_pc", o_ipc[0], 32'd0);
      chk("reset fetch_count", o_cnt[0], 32'd0);
      chk("reset fetch_fault", 32'(o_fault[0]), 32'd0);

      // First valid two cycles after release at latency 1.
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      cycle();
      chk("first valid too early", 32'(o_valid[0]), 32'd0);
      cycle();
      chk("first valid", 32'(o_valid[0]), 32'd1);
      chk("first instr", o_instr[0], 32'h0050_0093);
      chk("first instr_pc", o_ipc[0], 32'h0000_1000);

      repeat (10) cycle();
      chk("stall instr_valid", 32'(o_valid[0]), 32'd1);
      chk("stall pc", o_addr[0], 32'h0000_1000);
      chk("stall fetch_count", o_cnt[0], 32'd0);
      ready = 1'b1;
      cycle();
      ready = 1'b0;
      chk("accept fetch_count", o_cnt[0], 32'd1);
      chk("accept pc", o_addr[0], 32'h0000_1004);

      // Redirect during WAIT discards the in-flight word.
      cycle();
      redir_v  = 1'b1;
      redir_pc = 32'h0000_1040;
      cycle();
      redir_v = 1'b0;
      chk("wait redirect valid", 32'(o_valid[0]), 32'd0);
      cycle();
      chk("wait redirect no stale valid", 32'(o_valid[0]), 32'd0);
      cycle();
      chk("wait redirect instr_pc", o_ipc[0], 32'h0000_1040);

      redir_v  = 1'b1;
      redir_pc = 32'h0000_1008;
      cycle();
      redir_v = 1'b0;
      cycle();
      cycle();
      chk("at 1008 instr_pc", o_ipc[0], 32'h0000_1008);
      ready    = 1'b1;
      redir_v  = 1'b1;
      redir_pc = 32'h0000_2000;
      cycle();
      ready   = 1'b0;
      redir_v = 1'b0;
      chk("redirect+hs fetch_count", o_cnt[0], 32'd2);
      chk("redirect+hs pc", o_addr[0], 32'h0000_2000);
      cycle();
      cycle();
      chk("redirect+hs instr_pc", o_ipc[0], 32'h0000_2000);

      redir_v  = 1'b1;
      redir_pc = 32'hFFFF_FFFC;
      cycle();
      redir_v = 1'b0;
      cycle();
      cycle();
      ready = 1'b1;
      cycle();
      ready = 1'b0;
      chk("pc wrap", o_addr[0], 32'h0000_0000);

      redir_v  = 1'b1;
      redir_pc = 32'h0000_1042;
      cycle();
      redir_v = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("misalign fault", 32'(o_fault[0]), 32'd1);
      chk("misalign address", o_addr[0], 32'h0000_1042);
      ready    = 1'b1;
      redir_v  = 1'b1;
      redir_pc = 32'h0000_3000;
      repeat (5) cycle();
      ready   = 1'b0;
      redir_v = 1'b0;
      chk("fault sticky", 32'(o_fault[0]), 32'd1);
      chk("fault no valid", 32'(o_valid[0]), 32'd0);
      chk("fault ignores redirect", o_addr[0], 32'h0000_1042);
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      cycle();
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      chk("fault cleared", 32'(o_fault[0]), 32'd0);
      chk("fault reset pc", o_addr[0], 32'h0000_1000);
`else
      cycle();
      cycle();
      chk("misalign aligned instr_pc", o_ipc[0], 32'h0000_1040);
`endif

      // Random traffic against the model.
      repeat (400) begin
         ready   = ($urandom_range(0, 3) != 0);
         redir_v = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 7) == 0) redir_pc = 32'hFFFF_FFFC;
         else redir_pc = 32'h0000_1000 + 32'($urandom_range(0, 255)) * 4;
`ifndef FETCH_MISALIGN_TRAP_EN
         redir_pc = redir_pc | 32'($urandom_range(0, 3));
`endif
         cycle();
      end

      // Latency-3 unit: reset asserted while mid-WAIT.
      ready   = 1'b1;
      redir_v = 1'b0;
      found   = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (!m_valid[1] && !m_fault[1] && m_left[1] == 2) begin
            found = 1'b1;
            break;
         end
         cycle();
      end
      chk("lat3 mid-wait reached", 32'(found), 32'd1);
      rst[1] = 1'b1;
      cycle();
      rst[1] = 1'b0;
      chk("lat3 reset address", o_addr[1], 32'h0000_1000);
      chk("lat3 reset valid", 32'(o_valid[1]), 32'd0);
      chk("lat3 reset count", o_cnt[1], 32'd0);
      repeat (3) begin
         cycle();
         chk("lat3 no early valid", 32'(o_valid[1]), 32'd0);
      end
      cycle();
      chk("lat3 first valid", 32'(o_valid[1]), 32'd1);
      chk("lat3 first instr_pc", o_ipc[1], 32'h0000_1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
